multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle version of the MIPS datapath: one shared memory, one ALU, and IR/PC registers.
- It replaces the single-cycle combinational control decode.
- It sits beside the datapath. It reads the latched IR opcode and a memory ready handshake, and drives every mux select and write enable.
- It keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
run  input  1  enable; sampled only at instruction boundaries
opcode  input  6  IR[31:26]; stable from DECODE onward
mem_ready  input  1  shared memory completes the current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load qualified by ALU zero (beq)
pc_source  output  2  00 ALU result, 01 ALUOut register, 10 jump target
i_or_d  output  1  memory address: 0 PC, 1 ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR load
reg_dst  output  1  0 rt, 1 rd
mem_to_reg  output  1  0 ALUOut, 1 MDR
reg_write  output  1  register file write
alu_src_a  output  1  0 PC, 1 rs
alu_src_b  output  2  00 rt, 01 constant 1, 10 sign-ext imm, 11 sign-ext imm (branch offset)
alu_op  output  2  00 add, 01 sub, 10 funct-decoded
state  output  4  current state encoding, for debug
illegal_op  output  1  sticky unsupported-opcode flag
instr_count  output  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, instr_count=0, illegal_op=0.
  - All control outputs are 0 during and after reset until the FSM leaves IDLE.
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7.
  - ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, TRAP=13.
  - Codes 14–15 are unreachable; if entered they go to IDLE next cycle.
- Outputs decode from state. Any output not listed for a state is 0.
  - FETCH: mem_read=1, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready (the only Mealy terms).
  - DECODE: alu_src_b=11, alu_op=00 (speculative branch target into ALUOut).
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_read=1, i_or_d=1.
  - MEMWR: mem_write=1, i_or_d=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - EXEC: alu_src_a=1, alu_op=10.
  - ALUWB: reg_write=1, reg_dst=1.
  - ADDIWB: reg_write=1, reg_dst=0.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
- Transitions:
  - IDLE: go to FETCH if run=1, else stay.
  - FETCH, MEMRD, MEMWR: hold while mem_ready=0; strobes stay asserted for the whole wait.
  - FETCH → DECODE on mem_ready.
  - DECODE dispatches on opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - any other opcode → TRAP
  - MEMADR → MEMRD if opcode=100011, else MEMWR.
  - MEMRD → MEMWB on mem_ready.
  - EXEC → ALUWB.
  - ADDIEX → ADDIWB.
- Retire (instruction boundary):
  - Retiring states: MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and MEMWR with mem_ready=1.
  - On leaving a retiring state: go to FETCH if run=1, else IDLE.
  - instr_count increments by 1 on the same edge, wrapping from all-ones to 0.
- Latency (cycles with zero-wait memory, FETCH to next FETCH):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each memory wait cycle adds 1.
- TRAP:
  - illegal_op sets on entry and stays set until rst_n.
  - All strobes are 0 in TRAP. Stay while run=1; go to IDLE when run=0.
  - instr_count does not increment.
  - Re-entering FETCH from IDLE does not clear illegal_op.
- run=0 in the middle of an instruction is ignored; the instruction completes.
- Reset mid-operation aborts immediately: no partial write enable is asserted after rst_n falls.

Test Plan:
- Reset with run=0 → state=0, all strobes 0, instr_count=0. Raise run → state=1 next edge with mem_read=1.
- R-type (opcode 000000), mem_ready always 1:
  - State sequence 1,2,7,8,1.
  - reg_write=1 and reg_dst=1 only in state 8.
  - instr_count 0→1 after 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 in MEMRD:
  - State sequence 1,1,1,2,3,4,4,4,4,5,1.
  - ir_write pulses once; mem_to_reg=1 in state 5.
- sw (101011) then beq (000100):
  - sw: mem_write=1 only in state 6; the next state 1 arrives on mem_ready.
  - beq: pc_write_cond=1 and pc_source=01 in state 9; instr_count +2 in total.
- Opcode 111111:
  - State 13, illegal_op=1, all strobes 0.
  - Drop run → state 0 with illegal_op still 1.
  - Raise run → fetch resumes.
- Counter wrap with CNT_W=4: after 16 j instructions (000010, 3 cycles each), instr_count=0. Deassert run during EXEC of an R-type → ALUWB completes, then state 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and the MIPS datapath:
// opcode/memory handshake in, every mux select and write enable out.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath, with a retired-instruction
// counter and a sticky illegal-opcode flag.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    multicycle_ctrl_if.master  bus,
    output logic [3:0]         state,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12,
        TRAP   = 4'd13
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic       retire_c;
    state_e     boundary_c;

    logic       pc_write_c;
    logic       pc_write_cond_c;
    logic [1:0] pc_source_c;
    logic       i_or_d_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_dst_c;
    logic       mem_to_reg_c;
    logic       reg_write_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Where an instruction boundary leads: keep fetching or park.
    assign boundary_c = run ? FETCH : IDLE;

    always_comb begin
        state_d         = state_q;
        retire_c        = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        pc_source_c     = 2'b00;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        reg_dst_c       = 1'b0;
        mem_to_reg_c    = 1'b0;
        reg_write_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                // IR and PC capture only on the cycle the read completes.
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b_c = 2'b11;
                unique case (bus.opcode)
                    OP_RTYPE:      state_d = EXEC;
                    OP_LW, OP_SW:  state_d = MEMADR;
                    OP_BEQ:        state_d = BRANCH;
                    OP_ADDI:       state_d = ADDIEX;
                    OP_J:          state_d = JUMP;
                    default:       state_d = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                retire_c     = 1'b1;
                state_d      = boundary_c;
            end
            MEMWR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = boundary_c;
                end
            end
            EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                retire_c    = 1'b1;
                state_d     = boundary_c;
            end
            BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 2'b01;
                retire_c        = 1'b1;
                state_d         = boundary_c;
            end
            ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = ADDIWB;
            end
            ADDIWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = boundary_c;
            end
            JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
                retire_c    = 1'b1;
                state_d     = boundary_c;
            end
            TRAP: begin
                if (!run) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky trap flag and retire counter; only rst_n clears either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            if (state_d == TRAP) illegal_op <= 1'b1;
            if (retire_c) instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state             = state_q;
    assign bus.pc_write      = pc_write_c;
    assign bus.pc_write_cond = pc_write_cond_c;
    assign bus.pc_source     = pc_source_c;
    assign bus.i_or_d        = i_or_d_c;
    assign bus.mem_read      = mem_read_c;
    assign bus.mem_write     = mem_write_c;
    assign bus.ir_write      = ir_write_c;
    assign bus.reg_dst       = reg_dst_c;
    assign bus.mem_to_reg    = mem_to_reg_c;
    assign bus.reg_write     = reg_write_c;
    assign bus.alu_src_a     = alu_src_a_c;
    assign bus.alu_src_b     = alu_src_b_c;
    assign bus.alu_op        = alu_op_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each cycle's expected state, control
// word, flag and count are queued with the stimulus and compared mid-cycle.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct packed {
        logic       r;
        logic [5:0] op;
        logic       mr;
        logic [3:0] est;
        logic       ret;
        logic       set_ill;
    } step_t;

    typedef struct packed {
        logic [3:0]       st;
        logic [15:0]      ctrl;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic             clk;
    logic             rst_n;
    logic             run;
    logic [3:0]       dut_state;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .bus         (bus),
        .state       (dut_state),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t             sb [$];
    int               vectors;
    int               miscompares;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ill;
    logic             pend_ret;

    // Control word order: pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
    // mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op.
    function automatic logic [15:0] pack(input logic pw, input logic pwc, input logic [1:0] ps,
                                         input logic iod, input logic mrd, input logic mwr,
                                         input logic irw, input logic rd, input logic m2r,
                                         input logic rw, input logic sa, input logic [1:0] sb_,
                                         input logic [1:0] op);
        return {pw, pwc, ps, iod, mrd, mwr, irw, rd, m2r, rw, sa, sb_, op};
    endfunction

    function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic mr);
        case (s)
            4'd1:        return pack(mr, 0, 2'b00, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00);
            4'd2:        return pack(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00);
            4'd3, 4'd10: return pack(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00);
            4'd4:        return pack(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
            4'd5:        return pack(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00);
            4'd6:        return pack(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
            4'd7:        return pack(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10);
            4'd8:        return pack(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00);
            4'd9:        return pack(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01);
            4'd11:       return pack(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00);
            4'd12:       return pack(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
            default:     return 16'h0000;
        endcase
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st   = dut_state;
        o.ctrl = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op};
        o.ill  = illegal_op;
        o.cnt  = instr_count;
        return o;
    endfunction

    function automatic step_t st(input logic r, input logic [5:0] op, input logic mr,
                                 input logic [3:0] est, input logic ret, input logic set_ill);
        step_t s;
        s.r = r; s.op = op; s.mr = mr; s.est = est; s.ret = ret; s.set_ill = set_ill;
        return s;
    endfunction

    // Drive one cycle's inputs on the falling edge and queue what that cycle must show.
    task automatic drive(input step_t s);
        obs_t e;
        @(negedge clk);
        run           = s.r;
        bus.opcode    = s.op;
        bus.mem_ready = s.mr;
        if (pend_ret) exp_cnt = exp_cnt + CNT_W'(1);
        pend_ret = s.ret;
        if (s.set_ill) exp_ill = 1'b1;
        e.st   = s.est;
        e.ctrl = exp_ctrl(s.est, s.mr);
        e.ill  = exp_ill;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        step_t q [$];
        obs_t  got, want;
        q.push_back(st(0, OP_R, 0, 0, 0, 0));
        q.push_back(st(0, OP_R, 1, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                         i, got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
            end
        end
        @(posedge clk); #2 rst_n = 1'b1;
        q.delete();
        q.push_back(st(0, OP_R, 1, 0, 0, 0));
        q.push_back(st(1, OP_R, 1, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                         i, got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
            end
        end
    endtask

    task automatic test_rtype();
        step_t q [$];
        obs_t  got, want;
        q.push_back(st(1, OP_R, 1, 1, 0, 0));
        q.push_back(st(1, OP_R, 1, 2, 0, 0));
        q.push_back(st(1, OP_R, 1, 7, 0, 0));
        q.push_back(st(1, OP_R, 1, 8, 1, 0));
        foreach (q[i]) begin
            drive(q[i]);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL rtype[%0d]: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                         i, got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
            end
        end
    endtask

    task automatic test_lw_wait();
        step_t q [$];
        obs_t  got, want;
        q.push_back(st(1, OP_LW, 0, 1, 0, 0));
        q.push_back(st(1, OP_LW, 0, 1, 0, 0));
        q.push_back(st(1, OP_LW, 1, 1, 0, 0));
        q.push_back(st(1, OP_LW, 1, 2, 0, 0));
        q.push_back(st(1, OP_LW, 1, 3, 0, 0));
        q.push_back(st(1, OP_LW, 0, 4, 0, 0));
        q.push_back(st(1, OP_LW, 0, 4, 0, 0));
        q.push_back(st(1, OP_LW, 0, 4, 0, 0));
        q.push_back(st(1, OP_LW, 1, 4, 0, 0));
        q.push_back(st(1, OP_LW, 1, 5, 1, 0));
        foreach (q[i]) begin
            drive(q[i]);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL lw_wait[%0d]: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                         i, got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
            end
        end
    endtask

    task automatic test_sw_beq();
        step_t q [$];
        obs_t  got, want;
        q.push_back(st(1, OP_SW, 1, 1, 0, 0));
        q.push_back(st(1, OP_SW, 1, 2, 0, 0));
        q.push_back(st(1, OP_SW, 1, 3, 0, 0));
        q.push_back(st(1, OP_SW, 0, 6, 0, 0));
        q.push_back(st(1, OP_SW, 1, 6, 1, 0));
        q.push_back(st(1, OP_BEQ, 1, 1, 0, 0));
        q.push_back(st(1, OP_BEQ, 1, 2, 0, 0));
        q.push_back(st(1, OP_BEQ, 1, 9, 1, 0));
        foreach (q[i]) begin
            drive(q[i]);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL sw_beq[%0d]: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                         i, got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
            end
        end
    endtask

    task automatic test_trap();
        step_t q [$];
        obs_t  got, want;
        q.push_back(st(1, OP_BAD, 1, 1, 0, 0));
        q.push_back(st(1, OP_BAD, 1, 2, 0, 0));
        q.push_back(st(1, OP_BAD, 1, 13, 0, 1));
        q.push_back(st(1, OP_BAD, 1, 13, 0, 0));
        q.push_back(st(0, OP_BAD, 1, 13, 0, 0));
        q.push_back(st(0, OP_BAD, 1, 0, 0, 0));
        q.push_back(st(1, OP_R, 1, 0, 0, 0));
        q.push_back(st(1, OP_R, 0, 1, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL trap[%0d]: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                         i, got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
            end
        end
    endtask

    task automatic test_run_drop();
        step_t q [$];
        obs_t  got, want;
        q.push_back(st(1, OP_R, 1, 1, 0, 0));
        q.push_back(st(1, OP_R, 1, 2, 0, 0));
        q.push_back(st(0, OP_R, 1, 7, 0, 0));
        q.push_back(st(0, OP_R, 1, 8, 1, 0));
        q.push_back(st(0, OP_R, 1, 0, 0, 0));
        q.push_back(st(1, OP_R, 1, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL run_drop[%0d]: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                         i, got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
            end
        end
    endtask

    task automatic test_back_to_back_jumps();
        step_t q [$];
        obs_t  got, want;
        for (int n = 0; n < 16; n++) begin
            q.push_back(st(1, OP_J, 1, 1, 0, 0));
            q.push_back(st(1, OP_J, 1, 2, 0, 0));
            q.push_back(st(1, OP_J, 1, 12, 1, 0));
        end
        q.push_back(st(1, OP_J, 0, 1, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL jumps[%0d]: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                         i, got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
            end
        end
    endtask

    task automatic test_reset_abort();
        step_t q [$];
        obs_t  got, want, e;
        q.push_back(st(1, OP_SW, 1, 1, 0, 0));
        q.push_back(st(1, OP_SW, 1, 2, 0, 0));
        q.push_back(st(1, OP_SW, 1, 3, 0, 0));
        q.push_back(st(1, OP_SW, 0, 6, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL abort_pre[%0d]: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                         i, got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
            end
        end
        // Reset lands mid-cycle while the store is still waiting on memory.
        #1 rst_n = 1'b0;
        exp_cnt = '0; exp_ill = 1'b0; pend_ret = 1'b0;
        e.st = 4'd0; e.ctrl = 16'h0000; e.ill = 1'b0; e.cnt = '0;
        sb.push_back(e);
        #1;
        got = observe(); want = sb.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL abort_async: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                     got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        q.delete();
        q.push_back(st(0, OP_SW, 1, 0, 0, 0));
        q.push_back(st(0, OP_SW, 1, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL abort_post[%0d]: state %0d ctrl %h ill %b cnt %0d, want state %0d ctrl %h ill %b cnt %0d",
                         i, got.st, got.ctrl, got.ill, got.cnt, want.st, want.ctrl, want.ill, want.cnt);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        run           = 1'b0;
        bus.opcode    = 6'b000000;
        bus.mem_ready = 1'b0;
        vectors       = 0;
        miscompares   = 0;
        exp_cnt       = '0;
        exp_ill       = 1'b0;
        pend_ret      = 1'b0;

        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_beq();
        test_trap();
        test_run_drop();
        test_back_to_back_jumps();
        test_reset_abort();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
